// File: rtl/mem_initiator.sv
// Synthesizable bus initiator for the single-port valid/ready memory: runs a one-shot
// write / read-check / write-then-read-check sweep using an address-derived data pattern.
module mem_initiator #(
  parameter int          DEPTH      = 16,
  parameter int          WIDTH      = 16,
  parameter int          ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned SEED       = 16'hACE1,
  parameter int unsigned STRIDE     = 16'h0101,
  parameter int          TIMEOUT    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  input  logic                  ready_i
);

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DONE} state_t;

  localparam int WAIT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int WAIT_LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_LIMIT_I[WAIT_W-1:0];
  localparam logic [ADDR_WIDTH:0] DEPTH_C    = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

  state_t state_q, state_d;

  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic [WAIT_W-1:0]     wait_q;
  logic                  valid_q;
  logic                  wr_rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [ADDR_WIDTH:0]   err_cnt_q;
  logic [ADDR_WIDTH-1:0] first_err_q;
  logic                  timeout_q;

  logic [ADDR_WIDTH:0]   count_clamp;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  timeout_hit;

  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] idx;
    base = WIDTH'(SEED);
    step = WIDTH'(STRIDE);
    idx  = WIDTH'(a);
    return base + idx * step;
  endfunction

  assign count_clamp = (count_i > DEPTH_C) ? DEPTH_C : count_i;
  assign next_addr   = addr_q + ADDR_WIDTH'(1);
  assign beat_fire   = valid_q && ready_i;
  assign last_beat   = beat_fire && (remain_q == CNT_ONE);
  assign timeout_hit = (TIMEOUT != 0) && valid_q && !ready_i && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_clamp == '0 || mode_i == 2'b11) state_d = DONE;
          else if (mode_i == 2'b01)                 state_d = READ;
          else                                      state_d = WRITE;
        end
      end
      WRITE: begin
        if (timeout_hit)    state_d = DONE;
        else if (last_beat) state_d = (mode_q == 2'b10) ? TURN : DONE;
      end
      TURN:    state_d = READ;
      READ:    if (timeout_hit || last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_o = (state_q == DONE);
    busy_o = (state_q == WRITE) || (state_q == TURN) || (state_q == READ);
  end

  // Request fields are registered and forced to zero whenever valid is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mode_q       <= '0;
      start_addr_q <= '0;
      count_q      <= '0;
      remain_q     <= '0;
      wait_q       <= '0;
      valid_q      <= 1'b0;
      wr_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q       <= mode_i;
            start_addr_q <= start_addr_i;
            count_q      <= count_clamp;
            remain_q     <= count_clamp;
            wait_q       <= '0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            timeout_q    <= 1'b0;
            if (state_d == WRITE || state_d == READ) begin
              valid_q <= 1'b1;
              wr_rd_q <= (state_d == WRITE);
              addr_q  <= start_addr_i;
              wdata_q <= (state_d == WRITE) ? pattern(start_addr_i) : '0;
            end
          end
        end
        WRITE, READ: begin
          if (beat_fire) begin
            wait_q   <= '0;
            remain_q <= remain_q - CNT_ONE;
            if (!wr_rd_q && rdata_i != pattern(addr_q)) begin
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
              if (err_cnt_q == '0) first_err_q <= addr_q;
            end
            if (last_beat) begin
              valid_q <= 1'b0;
              wr_rd_q <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
            end else begin
              addr_q  <= next_addr;
              wdata_q <= wr_rd_q ? pattern(next_addr) : '0;
            end
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            valid_q   <= 1'b0;
            wr_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
          end else if (valid_q && TIMEOUT != 0) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        TURN: begin
          valid_q  <= 1'b1;
          wr_rd_q  <= 1'b0;
          addr_q   <= start_addr_q;
          wdata_q  <= '0;
          remain_q <= count_q;
          wait_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign valid_o          = valid_q;
  assign wr_rd_o          = wr_rd_q;
  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator: a small memory/responder model plus a
// beat monitor, with hand-computed expected beats and counters.
module tb_mem_initiator;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [AW-1:0]    start_addr;
  logic [AW:0]      count;
  logic             busy, done, timeout, valid, wr_rd, ready;
  logic [AW:0]      err_cnt;
  logic [AW-1:0]    first_err, addr;
  logic [WIDTH-1:0] wdata, rdata;

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] bd_image [DEPTH];
  logic             bd_load;
  int               rdy_mode;
  int               stall_cnt = 0;

  int errors = 0;
  int checks = 0;

  int cyc = 0, valid_cycles = 0, done_pulses = 0, hold_viol = 0;
  logic             prev_stall = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [WIDTH-1:0] prev_wdata = '0;
  int beat_wr[$], beat_addr[$], beat_data[$], beat_cyc[$];

  always #5 clk = ~clk;

  mem_initiator #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW),
    .SEED(16'hACE1), .STRIDE(16'h0101), .TIMEOUT(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode),
    .start_addr_i(start_addr), .count_i(count), .busy_o(busy), .done_o(done),
    .err_cnt_o(err_cnt), .first_err_addr_o(first_err), .timeout_o(timeout),
    .valid_o(valid), .wr_rd_o(wr_rd), .addr_o(addr), .wdata_o(wdata),
    .rdata_i(rdata), .ready_i(ready)
  );

  // Responder: ready always high, always low, or after three stall cycles per beat.
  assign ready = (rdy_mode == 0) || (rdy_mode == 2 && stall_cnt == 3);
  assign rdata = mem[addr];

  always @(posedge clk) begin
    if (bd_load) mem <= bd_image;
    else if (valid && ready && wr_rd) mem[addr] <= wdata;
    if (valid && !ready) stall_cnt <= stall_cnt + 1;
    else                 stall_cnt <= 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid) valid_cycles <= valid_cycles + 1;
    if (done)  done_pulses  <= done_pulses + 1;
    if (rst_n && !timeout && prev_stall &&
        (!valid || wr_rd !== prev_wr || addr !== prev_addr || wdata !== prev_wdata))
      hold_viol <= hold_viol + 1;
    prev_stall <= valid && !ready;
    prev_wr    <= wr_rd;
    prev_addr  <= addr;
    prev_wdata <= wdata;
    if (valid && ready) begin
      beat_wr.push_back(int'(wr_rd));
      beat_addr.push_back(int'(addr));
      beat_data.push_back(int'(wr_rd ? wdata : rdata));
      beat_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] a, input logic [AW:0] c);
    tick();
    start      = 1'b1;
    mode       = m;
    start_addr = a;
    count      = c;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  logic [15:0] exp_t1 [4]  = '{16'hACE1, 16'hADE2, 16'hAEE3, 16'hAFE4};
  int          exp_a2 [8]  = '{14, 15, 0, 1, 14, 15, 0, 1};
  logic [15:0] exp_d2 [8]  = '{16'hBAEF, 16'hBBF0, 16'hACE1, 16'hADE2,
                               16'hBAEF, 16'hBBF0, 16'hACE1, 16'hADE2};
  logic [15:0] exp_d4 [3]  = '{16'hB2E7, 16'hB3E8, 16'hB4E9};

  initial begin
    int n, base, vc0, dp0, hv0;
    rst_n = 1'b1; start = 1'b0; mode = '0; start_addr = '0; count = '0;
    rdy_mode = 0; bd_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_addr", addr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] write 4 from address 0");
    base = beat_addr.size(); vc0 = valid_cycles;
    applyStimulus(2'b00, 4'd0, 5'd4);
    checkOutput("t1_busy", busy, 1);
    waitDone(n);
    checkOutput("t1_latency", n, 4);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_err", err_cnt, 0);
    checkOutput("t1_nbeats", beat_addr.size() - base, 4);
    checkOutput("t1_valid_cycles", valid_cycles - vc0, 4);
    for (int i = 0; i < 4 && base + i < beat_addr.size(); i++) begin
      checkOutput("t1_wr", beat_wr[base+i], 1);
      checkOutput("t1_addr", beat_addr[base+i], i);
      checkOutput("t1_data", beat_data[base+i], exp_t1[i]);
    end
    tick();
    checkOutput("t1_done_one_cycle", done, 0);

    $display("[TB] write then read-check 4 from address 14");
    base = beat_addr.size();
    applyStimulus(2'b10, 4'd14, 5'd4);
    waitDone(n);
    checkOutput("t2_latency", n, 9);
    checkOutput("t2_err", err_cnt, 0);
    checkOutput("t2_timeout", timeout, 0);
    checkOutput("t2_nbeats", beat_addr.size() - base, 8);
    for (int i = 0; i < 8 && base + i < beat_addr.size(); i++) begin
      checkOutput("t2_wr", beat_wr[base+i], (i < 4) ? 1 : 0);
      checkOutput("t2_addr", beat_addr[base+i], exp_a2[i]);
      checkOutput("t2_data", beat_data[base+i], exp_d2[i]);
    end
    if (beat_cyc.size() >= base + 5)
      checkOutput("t2_turn_gap", beat_cyc[base+4] - beat_cyc[base+3], 2);
    tick();

    $display("[TB] read-check 16 with mem[5] corrupted");
    for (int i = 0; i < DEPTH; i++) bd_image[i] = 16'hACE1 + 16'(i) * 16'h0101;
    bd_image[5] = 16'h0000;
    bd_load = 1'b1;
    tick();
    bd_load = 1'b0;
    applyStimulus(2'b01, 4'd0, 5'd16);
    waitDone(n);
    checkOutput("t3_latency", n, 16);
    checkOutput("t3_err", err_cnt, 1);
    checkOutput("t3_first_err", first_err, 5);
    tick();
    checkOutput("t3_err_hold", err_cnt, 1);

    $display("[TB] write 3 from address 6 with 3-cycle stalls");
    rdy_mode = 2;
    base = beat_addr.size(); vc0 = valid_cycles; hv0 = hold_viol;
    applyStimulus(2'b00, 4'd6, 5'd3);
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    waitDone(n);
    checkOutput("t4_latency", n, 11);
    checkOutput("t4_nbeats", beat_addr.size() - base, 3);
    checkOutput("t4_valid_cycles", valid_cycles - vc0, 12);
    checkOutput("t4_hold", hold_viol - hv0, 0);
    for (int i = 0; i < 3 && base + i < beat_addr.size(); i++) begin
      checkOutput("t4_wr", beat_wr[base+i], 1);
      checkOutput("t4_addr", beat_addr[base+i], 6 + i);
      checkOutput("t4_data", beat_data[base+i], exp_d4[i]);
    end
    tick();
    checkOutput("t4_idle_busy", busy, 0);
    checkOutput("t4_idle_valid", valid, 0);
    rdy_mode = 0;

    $display("[TB] ready stuck low, timeout");
    rdy_mode = 1;
    base = beat_addr.size(); vc0 = valid_cycles; dp0 = done_pulses;
    applyStimulus(2'b01, 4'd0, 5'd2);
    waitDone(n);
    checkOutput("t5_latency", n, 32);
    checkOutput("t5_timeout", timeout, 1);
    checkOutput("t5_valid_dropped", valid, 0);
    checkOutput("t5_valid_cycles", valid_cycles - vc0, 32);
    checkOutput("t5_nbeats", beat_addr.size() - base, 0);
    repeat (3) tick();
    checkOutput("t5_done_pulses", done_pulses - dp0, 1);
    checkOutput("t5_timeout_hold", timeout, 1);
    rdy_mode = 0;

    $display("[TB] reset mid-read");
    applyStimulus(2'b01, 4'd0, 5'd8);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", valid, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_timeout", timeout, 0);
    checkOutput("t6_rst_addr", addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    vc0 = valid_cycles; base = beat_addr.size();
    applyStimulus(2'b00, 4'd3, 5'd0);
    waitDone(n);
    checkOutput("t6_count0_latency", n, 0);
    tick();
    applyStimulus(2'b11, 4'd2, 5'd4);
    waitDone(n);
    checkOutput("t6_noop_latency", n, 0);
    checkOutput("t6_no_valid", valid_cycles - vc0, 0);
    tick();

    $display("[TB] count above depth is clamped");
    base = beat_addr.size();
    applyStimulus(2'b00, 4'd0, 5'd31);
    waitDone(n);
    checkOutput("t7_latency", n, 16);
    checkOutput("t7_nbeats", beat_addr.size() - base, 16);
    if (beat_addr.size() >= base + 16) begin
      checkOutput("t7_last_addr", beat_addr[base+15], 15);
      checkOutput("t7_last_data", beat_data[base+15], 16'hBBF0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Bus initiator for the single-port valid/ready memory block. It takes a one-shot command (write, read-check, or write-then-read-check over an address range) and drives the memory request interface. Write data comes from a deterministic address pattern. Read data is checked against the same pattern, with error counting and capture of the first failing address. It sits between a test/control sequencer and the memory, replacing bench-level write/read tasks with synthesizable RTL.

Parameters:
DEPTH, 16, number of memory words; power of two, at least 2
WIDTH, 16, data width in bits
ADDR_WIDTH, $clog2(DEPTH), address width
SEED, 16'hACE1, pattern base value, truncated or zero-extended to WIDTH
STRIDE, 16'h0101, pattern per-address increment, truncated or zero-extended to WIDTH
TIMEOUT, 32, maximum cycles to wait for ready_i per beat; 0 disables the timeout

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  command strobe; sampled only in IDLE
mode_i  input  2  00 = write, 01 = read-check, 10 = write then read-check, 11 = reserved (treated as no-op)
start_addr_i  input  ADDR_WIDTH  first address
count_i  input  ADDR_WIDTH+1  number of beats, 0..DEPTH
busy_o  output  1  high from command accept until done_o
done_o  output  1  one-cycle completion pulse
err_cnt_o  output  ADDR_WIDTH+1  read mismatches in the last command; saturates at all-ones
first_err_addr_o  output  ADDR_WIDTH  address of the first mismatch
timeout_o  output  1  last command aborted on timeout
valid_o  output  1  memory request valid
wr_rd_o  output  1  1 = write, 0 = read
addr_o  output  ADDR_WIDTH  request address
wdata_o  output  WIDTH  write data
rdata_i  input  WIDTH  memory read data
ready_i  input  1  memory accept / read-data-valid

Behaviour:
- Reset (rst_i low, at any time, including mid-command):
  - All outputs go to 0 immediately; FSM goes to IDLE.
  - Any in-flight beat is abandoned.
- Pattern: P(a) = (SEED + a*STRIDE) mod 2^WIDTH, where a is the wrapped address. For defaults, P(0)=ACE1, P(1)=ADE2, P(15)=BBF0.
- Handshake:
  - A beat completes on a rising clk_i edge where valid_o=1 and ready_i=1.
  - valid_o, wr_rd_o, addr_o and wdata_o are registered and held stable until that edge.
  - For reads, rdata_i is sampled on that same edge.
  - Back-to-back beats are allowed: on completion, the next beat's fields appear the following cycle with valid_o still high.
  - While valid_o=0, wr_rd_o, addr_o and wdata_o are 0.
- Addressing: the address increments by 1 per completed beat and wraps modulo DEPTH (DEPTH-1 -> 0). count_i greater than DEPTH is clamped to DEPTH.
- FSM states: IDLE, WRITE, TURN, READ, DONE.
  - IDLE:
    - start_i=1 latches mode_i, start_addr_i and count_i, clears err_cnt_o, first_err_addr_o and timeout_o, and sets busy_o.
    - With count 0 or mode 11, go to DONE.
    - With mode 00 or 10, go to WRITE; with mode 01, go to READ.
  - WRITE: drives write beats with wdata_o = P(addr_o). After the last beat: mode 10 goes to TURN, otherwise DONE.
  - TURN: one cycle with valid_o=0; the address reloads start_addr; go to READ.
  - READ: drives read beats. On each completion, if rdata_i != P(addr_o), increment err_cnt_o (saturating). On the first mismatch, capture first_err_addr_o. After the last beat, go to DONE.
  - DONE: valid_o=0, done_o=1 and busy_o=0 this cycle; err_cnt_o, first_err_addr_o and timeout_o hold their values until the next accepted start. Return to IDLE.
- Latency: the accepting edge is followed by valid_o high in the next cycle. The minimum command is count + 2 cycles (mode 00/01) or 2*count + 3 cycles (mode 10).
- Timeout:
  - A per-beat wait counter resets on each completion.
  - If TIMEOUT is nonzero and the counter reaches TIMEOUT while valid_o=1 and ready_i=0, set timeout_o, drop valid_o and go to DONE; remaining beats are skipped.
- start_i while busy is ignored. start_i in the DONE cycle is ignored.

Test Plan:
- Write 4 from address 0 with ready_i always 1 -> 4 consecutive valid cycles; beats are (0,ACE1), (1,ADE2), (2,AEE3), (3,AFE4); done_o 1 cycle later; err_cnt_o=0.
- Mode 10, start 14, count 4, connected to the memory -> writes to addresses 14, 15, 0, 1; one TURN cycle with valid_o=0; reads 14, 15, 0, 1; err_cnt_o=0; timeout_o=0.
- Read-check of 16 words from a memory back-door loaded with the pattern except mem[5]=0000 -> err_cnt_o=1; first_err_addr_o=5.
- Responder inserts 3-cycle ready_i stalls on every beat -> request fields held stable across each stall; no beat dropped or duplicated.
- ready_i tied 0, TIMEOUT=32 -> valid_o drops after 32 waiting cycles; timeout_o=1; done_o pulses once.
- rst_i low mid-read with count=8 -> all outputs 0 asynchronously; after release, start_i is accepted normally; count_i=0 gives done_o 1 cycle after accept with no valid_o.
